// File: rtl/buffer_arb_pkg.sv
// Shared types and defaults for the two-requester buffer arbiter.
// Holds the FSM state encoding, the owner encoding for round-robin and the tie-break rule.
package buffer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2,
        TURN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_1 = 2'd1,
        OWN_2 = 2'd2
    } owner_e;

    localparam int DEF_MAX_HOLD    = 4;
    localparam int DEF_TURN_CYCLES = 1;

    // A tie goes to the side that did not own the bus last.
    function automatic state_e arb_pick(input logic r1, input logic r2, input owner_e last);
        state_e pick;
        pick = IDLE;
        if (r1 && r2) begin
            pick = (last == OWN_1) ? GNT2 : GNT1;
        end else if (r1) begin
            pick = GNT1;
        end else if (r2) begin
            pick = GNT2;
        end
        return pick;
    endfunction

endpackage

// File: rtl/buffer_arb_buffer.sv
// Shared two-source bus driver: passes the enabled side's data, floats the bus otherwise.
// The arbiter guarantees the two enables are never high together.
module buffer #(
    parameter int data_width = 8
) (
    input  logic [data_width-1:0] data_in1,
    input  logic [data_width-1:0] data_in2,
    input  logic                  data_en1,
    input  logic                  data_en2,
    output logic [data_width-1:0] data_out
);

    assign data_out = data_en1 ? data_in1 :
                      data_en2 ? data_in2 : {data_width{1'bz}};

endmodule

// File: rtl/buffer_arb.sv
// Round-robin arbiter with bounded hold and a fixed turnaround gap, driving the shared buffer.
// Grants are decoded straight from the registered state, so they change only on clock edges.
module buffer_arb
    import buffer_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req1,
    input  logic                  req2,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    output logic                  gnt1,
    output logic                  gnt2,
    output logic                  bus_idle,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    state_e        state_q, state_d;
    owner_e        last_q, last_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] turn_cnt_q, turn_cnt_d;
    logic          release_now;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = arb_pick(req1, req2, last_q);
            end
            GNT1: begin
                release_now = !req1 || (req2 && hold_cnt_q == HW'(MAX_HOLD));
                if (release_now) begin
                    state_d    = TURN;
                    last_d     = OWN_1;
                    turn_cnt_d = '0;
                end
            end
            GNT2: begin
                release_now = !req2 || (req1 && hold_cnt_q == HW'(MAX_HOLD));
                if (release_now) begin
                    state_d    = TURN;
                    last_d     = OWN_2;
                    turn_cnt_d = '0;
                end
            end
            default: begin
                turn_cnt_d = turn_cnt_q + TW'(1);
                if (turn_cnt_q == TW'(TURN_CYCLES - 1)) begin
                    state_d = arb_pick(req1, req2, last_q);
                end
            end
        endcase

        // Hold count restarts at 1 on every new grant and saturates while the owner keeps the bus.
        if ((state_d == GNT1 || state_d == GNT2) && state_d != state_q) begin
            hold_cnt_d = HW'(1);
        end else if (state_d == GNT1 || state_d == GNT2) begin
            hold_cnt_d = (hold_cnt_q == HW'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + HW'(1);
        end else begin
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= OWN_2;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    assign gnt1     = (state_q == GNT1);
    assign gnt2     = (state_q == GNT2);
    assign bus_idle = !(gnt1 || gnt2);

    buffer #(
        .data_width(DATA_WIDTH)
    ) u_buffer (
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_en1 (gnt1),
        .data_en2 (gnt2),
        .data_out (data_out)
    );

endmodule

// File: tb/tb_buffer_arb.sv
// Bench for buffer_arb: two instances (hold 4/gap 1 and hold 3/gap 3) share stimulus and are
// compared every cycle against an owner/gap model, plus directed literal expectations.
module tb_buffer_arb;

    logic       clk;
    logic       rst;
    logic       req1, req2;
    logic [7:0] d1, d2;

    logic       g1_a, g2_a, bi_a;
    logic       g1_b, g2_b, bi_b;
    wire  [7:0] dout_a, dout_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    buffer_arb #(.DATA_WIDTH(8), .MAX_HOLD(4), .TURN_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .data_in1(d1), .data_in2(d2),
        .gnt1(g1_a), .gnt2(g2_a), .bus_idle(bi_a), .data_out(dout_a)
    );

    buffer_arb #(.DATA_WIDTH(8), .MAX_HOLD(3), .TURN_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .data_in1(d1), .data_in2(d2),
        .gnt1(g1_b), .gnt2(g2_b), .bus_idle(bi_b), .data_out(dout_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference model: who owns the bus, how long they have held it, remaining gap cycles.
    int m_owner[2];
    int m_held[2];
    int m_gap[2];
    int m_last[2];
    int mh[2] = '{4, 3};
    int tc[2] = '{1, 3};

    function automatic int choose(input int r1, input int r2, input int last);
        if (r1 != 0 && r2 != 0) return (last == 1) ? 2 : 1;
        if (r1 != 0) return 1;
        if (r2 != 0) return 2;
        return 0;
    endfunction

    task automatic model_step(input int k);
        int mine, other, c;
        if (rst) begin
            m_owner[k] = 0; m_held[k] = 0; m_gap[k] = 0; m_last[k] = 2;
        end else if (m_owner[k] != 0) begin
            mine  = (m_owner[k] == 1) ? int'(req1) : int'(req2);
            other = (m_owner[k] == 1) ? int'(req2) : int'(req1);
            if (mine == 0 || (other != 0 && m_held[k] >= mh[k])) begin
                m_last[k]  = m_owner[k];
                m_owner[k] = 0;
                m_held[k]  = 0;
                m_gap[k]   = tc[k];
            end else if (m_held[k] < mh[k]) begin
                m_held[k] = m_held[k] + 1;
            end
        end else if (m_gap[k] > 1) begin
            m_gap[k] = m_gap[k] - 1;
        end else begin
            m_gap[k] = 0;
            c = choose(int'(req1), int'(req2), m_last[k]);
            if (c != 0) begin
                m_owner[k] = c;
                m_held[k]  = 1;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0; m_held[k] = 0; m_gap[k] = 0; m_last[k] = 2;
        end
    end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_a_gnt1", 32'(g1_a), 32'(m_owner[0] == 1));
            chk("m_a_gnt2", 32'(g2_a), 32'(m_owner[0] == 2));
            chk("m_a_idle", 32'(bi_a), 32'(m_owner[0] == 0));
            chk("m_b_gnt1", 32'(g1_b), 32'(m_owner[1] == 1));
            chk("m_b_gnt2", 32'(g2_b), 32'(m_owner[1] == 2));
            chk("m_b_idle", 32'(bi_b), 32'(m_owner[1] == 0));
            chk("excl_a", 32'(g1_a & g2_a), 32'd0);
            chk("excl_b", 32'(g1_b & g2_b), 32'd0);
            if (m_owner[0] != 0)
                chk("m_a_dout", 32'(dout_a), 32'((m_owner[0] == 1) ? d1 : d2));
            if (m_owner[1] != 0)
                chk("m_b_dout", 32'(dout_b), 32'((m_owner[1] == 1) ? d1 : d2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int exp_o;

    initial begin
        rst = 1; req1 = 1; req2 = 1; d1 = 8'hA5; d2 = 8'h3C;

        // Reset held 3 cycles with both requests high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_en = 1;
            chk("rst_gnt1", 32'(g1_a), 32'd0);
            chk("rst_gnt2", 32'(g2_a), 32'd0);
            chk("rst_idle", 32'(bi_a), 32'd1);
        end
        rst = 0;
        tick();
        chk("first_gnt1", 32'(g1_a), 32'd1);
        chk("first_dout", 32'(dout_a), 32'hA5);

        // Both requesting: 4 grant cycles, 1 gap, alternating owners
        for (int i = 1; i < 30; i++) begin
            tick();
            exp_o = ((i % 10) < 4) ? 1 : ((i % 10) == 4) ? 0 : ((i % 10) < 9) ? 2 : 0;
            chk("rr_gnt1", 32'(g1_a), 32'(exp_o == 1));
            chk("rr_gnt2", 32'(g2_a), 32'(exp_o == 2));
        end

        // Single requester keeps the bus without preemption
        rst = 1; req1 = 0; req2 = 0; tick();
        rst = 0; tick();
        req2 = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("single_gnt2", 32'(g2_a), 32'd1);
            chk("single_gnt1", 32'(g1_a), 32'd0);
            chk("single_dout", 32'(dout_a), 32'h3C);
        end
        req2 = 0;
        tick();
        chk("single_rel", 32'(g2_a), 32'd0);
        tick();
        chk("single_idle", 32'(bi_a), 32'd1);

        // Turnaround of 3 cycles on the second instance
        rst = 1; tick();
        rst = 0; tick();
        req1 = 1; tick();
        chk("turn_g1_c1", 32'(g1_b), 32'd1);
        req2 = 1; tick();
        chk("turn_g1_c2", 32'(g1_b), 32'd1);
        req1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("turn_gap", 32'(bi_b), 32'd1);
        end
        tick();
        chk("turn_gnt2", 32'(g2_b), 32'd1);

        // Reset in the second cycle of a grant
        rst = 1; req1 = 0; req2 = 0; tick();
        rst = 0; req2 = 1; tick();
        chk("mid_g2_c1", 32'(g2_a), 32'd1);
        tick();
        chk("mid_g2_c2", 32'(g2_a), 32'd1);
        rst = 1; req1 = 1; tick();
        chk("mid_rst_g2", 32'(g2_a), 32'd0);
        chk("mid_rst_idle", 32'(bi_a), 32'd1);
        rst = 0; tick();
        chk("mid_after_g1", 32'(g1_a), 32'd1);

        // One-cycle request pulse in IDLE
        rst = 1; req1 = 0; req2 = 0; tick();
        rst = 0; tick();
        req1 = 1; tick();
        chk("pulse_gnt1", 32'(g1_a), 32'd1);
        req1 = 0; tick();
        chk("pulse_rel", 32'(g1_a), 32'd0);
        tick();
        chk("pulse_idle1", 32'(bi_a), 32'd1);
        tick();
        chk("pulse_idle2", 32'(bi_a), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            if ($urandom_range(0, 3) == 0) req2 = ~req2;
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            tick();
        end

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
